// File: rtl/csa_tree_pipe_if.sv
// Stream bundle for the CSA adder tree: one operand beat in, one accumulated result out.
// The master side drives beats and accepts results; the slave side is the tree itself.
interface csa_tree_pipe_if #(
  parameter int NUM_IN   = 25,
  parameter int DATA_BIT = 16,
  parameter int OUT_BIT  = 24
);
  logic                         in_valid;
  logic                         in_ready;
  logic [NUM_IN*DATA_BIT-1:0]   in_data;
  logic                         in_first;
  logic                         in_last;
  logic                         out_valid;
  logic                         out_ready;
  logic [OUT_BIT-1:0]           out_data;

  modport master (
    output in_valid, in_data, in_first, in_last, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_first, in_last, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/csa_tree_pipe.sv
// Pipelined carry-save adder tree with a final carry-propagate adder and a
// multi-beat accumulator. Each 3:2 level is registered; leftover operands ride
// along registered. The whole pipe stalls as one unit when a result is held.
module csa_tree_pipe #(
  parameter int NUM_IN   = 25,
  parameter int DATA_BIT = 16,
  parameter int OUT_BIT  = 24,
  parameter bit SIGNED   = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  csa_tree_pipe_if.slave   bus
);

  // Operand count after one 3:2 level.
  function automatic int next_count(input int n);
    return 2 * (n / 3) + (n % 3);
  endfunction

  // Operand count present at the output of level lvl (level 0 = input register).
  function automatic int count_at(input int lvl);
    int n;
    n = NUM_IN;
    for (int i = 0; i < lvl; i++) n = next_count(n);
    return n;
  endfunction

  // Number of 3:2 levels needed to reach two operands.
  function automatic int num_levels();
    int n;
    int l;
    n = NUM_IN;
    l = 0;
    while (n > 2) begin
      n = next_count(n);
      l++;
    end
    return l;
  endfunction

  localparam int LEVELS = num_levels();

  // Data per stage; only the first count_at(stage) entries of a row are live.
  logic [OUT_BIT-1:0] lvl_data [0:LEVELS][0:NUM_IN-1];
  logic [LEVELS:0]    valid_reg;
  logic [LEVELS:0]    first_reg;
  logic [LEVELS:0]    last_reg;

  logic               en;
  logic [OUT_BIT-1:0] acc_reg;
  logic [OUT_BIT-1:0] res_data_reg;
  logic               res_valid_reg;
  logic [OUT_BIT-1:0] cpa_sum;
  logic [OUT_BIT-1:0] acc_next;

  // A held, unaccepted result freezes every stage at once.
  assign en           = !res_valid_reg || bus.out_ready;
  assign bus.in_ready = en;
  assign bus.out_valid = res_valid_reg;
  assign bus.out_data  = res_data_reg;

  // Beat control flags travel alongside the data; flags only load on acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_reg <= '0;
      first_reg <= '0;
      last_reg  <= '0;
    end else if (en) begin
      valid_reg[0] <= bus.in_valid;
      if (bus.in_valid) begin
        first_reg[0] <= bus.in_first;
        last_reg[0]  <= bus.in_last;
      end
      for (int i = 1; i <= LEVELS; i++) begin
        valid_reg[i] <= valid_reg[i-1];
        first_reg[i] <= first_reg[i-1];
        last_reg[i]  <= last_reg[i-1];
      end
    end
  end

  genvar gl, gi;
  generate
    for (gl = 0; gl <= LEVELS; gl++) begin : g_lvl
      localparam int CNT = count_at(gl);
      if (gl == 0) begin : g_in
        for (gi = 0; gi < CNT; gi++) begin : g_op
          logic [DATA_BIT-1:0] raw;
          logic [OUT_BIT-1:0]  ext;
          assign raw = bus.in_data[gi*DATA_BIT +: DATA_BIT];
          if (SIGNED) begin : g_sext
            assign ext = OUT_BIT'($signed(raw));
          end else begin : g_zext
            assign ext = OUT_BIT'(raw);
          end
          // Capture the widened operand when the beat is accepted.
          always_ff @(posedge clk or posedge reset) begin
            if (reset)                    lvl_data[gl][gi] <= '0;
            else if (en && bus.in_valid)  lvl_data[gl][gi] <= ext;
          end
        end
      end else begin : g_csa
        localparam int PREV = count_at(gl - 1);
        localparam int GRP  = PREV / 3;
        for (gi = 0; gi < CNT; gi++) begin : g_op
          logic [OUT_BIT-1:0] nxt;
          if (gi < 2 * GRP) begin : g_fa
            // Even slot is the group's sum word, odd slot its shifted carry word.
            logic [OUT_BIT-1:0] a, b, c;
            assign a = lvl_data[gl-1][3*(gi/2)];
            assign b = lvl_data[gl-1][3*(gi/2)+1];
            assign c = lvl_data[gl-1][3*(gi/2)+2];
            if (gi % 2 == 0) begin : g_sum
              assign nxt = a ^ b ^ c;
            end else begin : g_carry
              assign nxt = ((a & b) | (a & c) | (b & c)) << 1;
            end
          end else begin : g_pass
            assign nxt = lvl_data[gl-1][3*GRP + (gi - 2*GRP)];
          end
          // Register this level's word.
          always_ff @(posedge clk or posedge reset) begin
            if (reset)   lvl_data[gl][gi] <= '0;
            else if (en) lvl_data[gl][gi] <= nxt;
          end
        end
      end
    end
  endgenerate

  assign cpa_sum  = lvl_data[LEVELS][0] + lvl_data[LEVELS][1];
  assign acc_next = first_reg[LEVELS] ? cpa_sum : acc_reg + cpa_sum;

  // Accumulate each valid beat; a last beat publishes the running total.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_reg       <= '0;
      res_data_reg  <= '0;
      res_valid_reg <= 1'b0;
    end else if (en) begin
      if (valid_reg[LEVELS]) acc_reg <= acc_next;
      res_valid_reg <= valid_reg[LEVELS] && last_reg[LEVELS];
      if (valid_reg[LEVELS] && last_reg[LEVELS]) res_data_reg <= acc_next;
    end
  end

endmodule
